// File: rtl/crc32_lut_seq.sv
// crc32_lut_seq: byte-serial CRC-32 sequencer in front of a shared 256-entry lookup table.
//
// Takes 32-bit words on a valid/ready stream and does one table lookup per byte, least
// significant byte first. The running CRC is kept across words of a frame. The finished
// CRC (crc ^ XOROUT) is offered on a valid/ready output.
//
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   in_valid/in_ready      input word handshake
//   in_data                data word, byte 0 = in_data[7:0]
//   in_first, in_last      frame delimiters (in_first reseeds the CRC)
//   in_nbytes              valid bytes in a last word (0 means 4)
//   tab_en, tab_addr       table lookup request (combinational from state)
//   tab_rdata              table entry at tab_addr, same cycle
//   out_valid/out_ready    final CRC handshake
//   out_crc                crc ^ XOROUT
//   busy                   high whenever not idle
module crc32_lut_seq #(
  parameter logic [31:0] INIT   = 32'hFFFFFFFF,
  parameter logic [31:0] XOROUT = 32'hFFFFFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_first,
  input  logic        in_last,
  input  logic [2:0]  in_nbytes,
  output logic        tab_en,
  output logic [7:0]  tab_addr,
  input  logic [31:0] tab_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_crc,
  output logic        busy
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e      state_q, state_d;
  logic [31:0] crc_q, crc_d;
  logic [31:0] data_q, data_d;
  logic        last_q, last_d;
  logic [1:0]  k_q, k_d;
  logic [2:0]  n_q, n_d;
  logic [7:0]  cur_byte;
  logic        byte_done;

  always_comb begin
    cur_byte = 8'h00;
    unique case (k_q)
      2'd0: cur_byte = data_q[7:0];
      2'd1: cur_byte = data_q[15:8];
      2'd2: cur_byte = data_q[23:16];
      2'd3: cur_byte = data_q[31:24];
      default: cur_byte = 8'h00;
    endcase
  end

  assign byte_done = ({1'b0, k_q} == (n_q - 3'd1));

  always_comb begin
    state_d   = state_q;
    crc_d     = crc_q;
    data_d    = data_q;
    last_d    = last_q;
    k_d       = k_q;
    n_d       = n_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    tab_en    = 1'b0;
    tab_addr  = 8'h00;

    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) begin
          data_d = in_data;
          last_d = in_last;
          // Out-of-range counts (5..7) are treated as a full word so k always reaches n-1.
          n_d    = (in_last && (in_nbytes inside {3'd1, 3'd2, 3'd3})) ? in_nbytes : 3'd4;
          k_d    = 2'd0;
          if (in_first) begin
            crc_d = INIT;
          end
          state_d = StBusy;
        end
      end
      StBusy: begin
        tab_en   = 1'b1;
        tab_addr = crc_q[7:0] ^ cur_byte;
        crc_d    = {8'h00, crc_q[31:8]} ^ tab_rdata;
        k_d      = k_q + 2'd1;
        if (byte_done) begin
          state_d = last_q ? StDone : StIdle;
        end
      end
      StDone: begin
        out_valid = 1'b1;
        if (out_ready) begin
          // Reseed here so a following frame without in_first still starts from INIT.
          crc_d   = INIT;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign busy    = (state_q != StIdle);
  assign out_crc = crc_q ^ XOROUT;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      crc_q   <= INIT;
      data_q  <= 32'h0;
      last_q  <= 1'b0;
      k_q     <= 2'd0;
      n_q     <= 3'd4;
    end else begin
      state_q <= state_d;
      crc_q   <= crc_d;
      data_q  <= data_d;
      last_q  <= last_d;
      k_q     <= k_d;
      n_q     <= n_d;
    end
  end

endmodule

// File: tb/tb_crc32_lut_seq.sv
// Self-checking bench for crc32_lut_seq with a scoreboard of expected frame CRCs and a
// bit-serial reference CRC-32 model; the lookup table is modelled as a combinational function.
module tb_crc32_lut_seq;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_first;
  logic        in_last;
  logic [2:0]  in_nbytes;
  logic        tab_en;
  logic [7:0]  tab_addr;
  logic [31:0] tab_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_crc;
  logic        busy;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic [31:0] exp_q[$];
  logic [31:0] m_crc = 32'hFFFFFFFF;
  logic [31:0] last_crc = 32'h0;

  crc32_lut_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_first  (in_first),
    .in_last   (in_last),
    .in_nbytes (in_nbytes),
    .tab_en    (tab_en),
    .tab_addr  (tab_addr),
    .tab_rdata (tab_rdata),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_crc   (out_crc),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] tab_entry(input logic [7:0] a);
    logic [31:0] c;
    c = {24'h0, a};
    for (int i = 0; i < 8; i++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    return c;
  endfunction

  assign tab_rdata = tab_entry(tab_addr);

  // Bit-serial reference, independent of the table path.
  function automatic logic [31:0] crc_byte(input logic [31:0] c_in, input logic [7:0] b);
    logic [31:0] c;
    c = c_in;
    for (int i = 0; i < 8; i++) begin
      c = (c[0] ^ b[i]) ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Offer one word, wait (bounded) for acceptance; returns 1 ns after the accepting edge.
  task automatic send_word(input logic [31:0] d, input logic f, input logic l,
                           input logic [2:0] nb);
    int guard;
    int n;
    in_valid  = 1'b1;
    in_data   = d;
    in_first  = f;
    in_last   = l;
    in_nbytes = nb;
    guard = 0;
    while (!in_ready && guard < 100) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (guard >= 100) check("accept_timeout", 32'(guard), 32'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (f) m_crc = 32'hFFFFFFFF;
    n = (l && nb != 0) ? int'(nb) : 4;
    for (int i = 0; i < n; i++) m_crc = crc_byte(m_crc, d[8*i +: 8]);
    if (l) begin
      exp_q.push_back(m_crc ^ 32'hFFFFFFFF);
      m_crc = 32'hFFFFFFFF;
    end
  endtask

  // Count cycles and lookups from acceptance until out_valid.
  task automatic wait_out(output int cyc, output int en_cnt);
    cyc = 0;
    en_cnt = 0;
    while (!out_valid && cyc < 50) begin
      if (tab_en) en_cnt++;
      @(posedge clk);
      #1;
      cyc++;
    end
    if (cyc >= 50) check("out_timeout", 32'(cyc), 32'd0);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      logic [31:0] e;
      e = (exp_q.size() != 0) ? exp_q.pop_front() : ~out_crc;
      check("sb_crc", out_crc, e);
      last_crc = out_crc;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int cyc;
    int cnt;
    logic [31:0] held;
    int nw;
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = 32'h0;
    in_first = 1'b0;
    in_last = 1'b0;
    in_nbytes = 3'd0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_crc", out_crc, 32'h0);
    check("rst_tab_en", 32'(tab_en), 32'd0);
    check("rst_tab_addr", 32'(tab_addr), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    step();

    // Zero word frame.
    send_word(32'h0, 1'b1, 1'b1, 3'd4);
    wait_out(cyc, cnt);
    check("zero_latency", 32'(cyc), 32'd4);
    check("zero_lookups", 32'(cnt), 32'd4);
    check("zero_tab_en_done", 32'(tab_en), 32'd0);
    step();
    check("zero_crc", last_crc, 32'h2144DF1C);

    // "123456789".
    send_word(32'h34333231, 1'b1, 1'b0, 3'd0);
    send_word(32'h38373635, 1'b0, 1'b0, 3'd0);
    send_word(32'h00000039, 1'b0, 1'b1, 3'd1);
    wait_out(cyc, cnt);
    check("str_last_latency", 32'(cyc), 32'd1);
    check("str_last_lookups", 32'(cnt), 32'd1);
    step();
    check("str_crc", last_crc, 32'hCBF43926);

    // Single byte, upper bytes ignored.
    send_word(32'hFFFFFF00, 1'b1, 1'b1, 3'd1);
    wait_out(cyc, cnt);
    check("byte_latency", 32'(cyc), 32'd1);
    step();
    check("byte_crc", last_crc, 32'hD202EF8D);

    // nbytes=0 means a full word.
    send_word(32'h0, 1'b1, 1'b1, 3'd0);
    wait_out(cyc, cnt);
    check("nb0_latency", 32'(cyc), 32'd4);
    step();
    check("nb0_crc", last_crc, 32'h2144DF1C);

    // Frame without in_first still starts from INIT.
    send_word(32'h34333231, 1'b0, 1'b0, 3'd0);
    send_word(32'h38373635, 1'b0, 1'b0, 3'd0);
    send_word(32'h00000039, 1'b0, 1'b1, 3'd1);
    wait_out(cyc, cnt);
    step();
    check("nofirst_crc", last_crc, 32'hCBF43926);

    // Backpressure.
    out_ready = 1'b0;
    send_word(32'h0, 1'b1, 1'b1, 3'd4);
    wait_out(cyc, cnt);
    check("bp_latency", 32'(cyc), 32'd4);
    held = out_crc;
    in_valid = 1'b1;
    in_data = 32'hDEADBEEF;
    in_first = 1'b1;
    in_last = 1'b1;
    in_nbytes = 3'd4;
    for (int i = 0; i < 10; i++) begin
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_out_crc", out_crc, 32'h2144DF1C);
      check("bp_crc_stable", out_crc, held);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_tab_en", 32'(tab_en), 32'd0);
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    check("bp_in_ready_after", 32'(in_ready), 32'd1);
    check("bp_out_valid_after", 32'(out_valid), 32'd0);
    check("bp_crc", last_crc, 32'h2144DF1C);

    // Reset during BUSY of the second word.
    send_word(32'h34333231, 1'b1, 1'b0, 3'd0);
    send_word(32'h38373635, 1'b0, 1'b0, 3'd0);
    step();
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_tab_en", 32'(tab_en), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    m_crc = 32'hFFFFFFFF;
    step();
    rst = 1'b0;
    step();
    send_word(32'h34333231, 1'b1, 1'b0, 3'd0);
    send_word(32'h38373635, 1'b0, 1'b0, 3'd0);
    send_word(32'h00000039, 1'b0, 1'b1, 3'd1);
    wait_out(cyc, cnt);
    step();
    check("rst_resend_crc", last_crc, 32'hCBF43926);

    // Random frames checked against the reference model through the scoreboard.
    for (int f = 0; f < 6; f++) begin
      nw = int'($urandom_range(1, 3));
      for (int w = 0; w < nw; w++) begin
        send_word($urandom, (w == 0), (w == nw - 1), 3'($urandom_range(0, 4)));
      end
      wait_out(cyc, cnt);
      step();
    end

    step();
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/crc32_lut_seq.md
# crc32_lut_seq

Byte-serial CRC-32 sequencer that drives one shared 256-entry CRC lookup table. It accepts 32-bit data words over a valid/ready stream and issues one table lookup per byte. It accumulates the running CRC and returns the finished frame CRC on an output valid/ready handshake. The block sits between the packet datapath and a combinational table module (8-bit address in, 32-bit entry out, same-cycle read).

## Interface
- `INIT`, default 32'hFFFFFFFF: CRC seed loaded at frame start.
- `XOROUT`, default 32'hFFFFFFFF: value XORed into the final CRC.
- `clk`, input, 1: single clock; all state changes on the rising edge.
- `rst`, input, 1: reset, asynchronous, active-high.
- `in_valid`, input, 1: data word offered.
- `in_ready`, output, 1: block can accept a word.
- `in_data`, input, 32: data word; byte 0 is `in_data[7:0]` and is processed first.
- `in_first`, input, 1: word starts a frame; reseeds the CRC to `INIT`.
- `in_last`, input, 1: word ends a frame.
- `in_nbytes`, input, 3: valid bytes in a last word (1–4; 0 means 4); ignored unless `in_last`.
- `tab_en`, output, 1: table lookup active this cycle.
- `tab_addr`, output, 8: table index.
- `tab_rdata`, input, 32: table entry at `tab_addr`, combinational.
- `out_valid`, output, 1: final CRC available.
- `out_ready`, input, 1: consumer takes the CRC.
- `out_crc`, output, 32: final CRC, equal to `crc ^ XOROUT`.
- `busy`, output, 1: high when state is not IDLE.

## Operation
- States:
  - **IDLE**: `in_ready`=1.
  - **BUSY**: per-byte lookup; a 2-bit byte counter `k` and a byte count `n` are held.
  - **DONE**: `out_valid`=1.
- IDLE, `in_valid`=1: the word is accepted (`in_valid`&`in_ready`).
  - Register `in_data` and `in_last`.
  - `n` = `in_last` ? (`in_nbytes`==0 ? 4 : `in_nbytes`) : 4.
  - `k`=0; `crc` = `INIT` if `in_first`, else unchanged.
  - Go to BUSY.
- BUSY, each cycle:
  - `b` = byte `k` of the registered word.
  - `tab_addr` = `crc[7:0] ^ b`; `tab_en`=1.
  - `crc` <= `{8'h00, crc[31:8]} ^ tab_rdata`; `k`++.
  - When `k`==`n`-1: go to DONE if the registered last flag is set, else IDLE.
- DONE: `out_crc` = `crc ^ XOROUT`, held stable while `out_valid` and not `out_ready`.
  - On `out_valid`&`out_ready`: `crc` <= `INIT`, go to IDLE.
- A frame whose first word lacks `in_first` still starts from `INIT`, because `crc` is reloaded at reset and at DONE exit. A mid-frame `in_first` restarts the frame and discards the partial CRC.
- `in_first`=`in_last`=1 on one word is a single-word frame.
- Outside BUSY: `tab_en`=0, `tab_addr`=0.
- Reset, at any time including mid-frame: state IDLE, `crc`=`INIT`, `k`=0, `n`=4. All outputs are as listed under Timing. The partial frame is dropped and no CRC is output.

## Timing
- Values after reset: `in_ready`=1, `out_valid`=0, `out_crc`=`INIT^XOROUT` (0 with the default parameters), `tab_en`=0, `tab_addr`=0, `busy`=0.
- `in_ready` is combinational from state only; no combinational path exists from `in_valid` to `in_ready`.
- `tab_addr` is combinational from registered state; the path `tab_rdata`→`crc` is registered in the same cycle.
- Latency: a word accepted at edge E0 occupies BUSY for `n` cycles.
  - Last word: `out_valid` rises at edge E`n`.
  - Non-last word: `in_ready` rises at edge E`n`.
- Throughput: one full word per 5 cycles with `in_valid` held high (4 BUSY + 1 IDLE).
- `out_valid` stays high until the handshake completes.
  - `in_ready`=0 throughout DONE (backpressure).
  - `in_ready`=1 in the cycle after the handshake.

## Test plan
- Zero frame: reset, then one word 32'h00000000 with first=1, last=1, nbytes=4, `out_ready`=1.
  - `tab_en` high for exactly 4 cycles.
  - `out_crc`=32'h2144DF1C, `out_valid` at E4.
- Check string "123456789": words 32'h34333231 (first), 32'h38373635, 32'h00000039 (last, nbytes=1).
  - `out_crc`=32'hCBF43926.
  - Final word has 1 BUSY cycle.
- Single byte: word 32'hFFFFFF00, first=1, last=1, nbytes=1.
  - `out_crc`=32'hD202EF8D; upper bytes are ignored.
- nbytes=0 on the last word: zero frame as in the first case but with nbytes=0.
  - Behaves as nbytes=4, `out_crc`=32'h2144DF1C.
- Backpressure: zero frame with `out_ready` held low for 10 cycles.
  - `out_valid`=1 and `out_crc` stable throughout; `in_ready`=0 with `in_valid` held high; no lookup issued.
  - After `out_ready`=1: one handshake, then `in_ready`=1 the next cycle.
- Reset mid-frame: assert `rst` during BUSY of the second word of "123456789", then resend the full frame.
  - Immediately after `rst`: `out_valid`=0, `tab_en`=0, `busy`=0.
  - Resent frame yields 32'hCBF43926.
